// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and reference Hamming construction for the
// serial stream encoder.
package hamming_pkg;

    localparam int M_MAX = 5;
    localparam int N_MAX = (1 << M_MAX) - 1;
    localparam int K_MAX = N_MAX - M_MAX;

    typedef enum logic {ST_IDLE, ST_SHIFT} enc_state_t;

    function automatic int k_of(input int m);
        return (1 << m) - 1 - m;
    endfunction

    function automatic int n_of(input int m);
        return (1 << m) - 1;
    endfunction

    function automatic int l_of(input int m, input int ext);
        return n_of(m) + ((ext != 0) ? 1 : 0);
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword bit (pos-1) holds position pos; bits above n_of(m) stay zero.
    function automatic logic [N_MAX-1:0] hamming_encode(input logic [K_MAX-1:0] data,
                                                        input int m);
        logic [N_MAX-1:0] cw;
        logic             p;
        int               di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= N_MAX; pos++) begin
            if (pos <= n_of(m) && !is_pow2(pos)) begin
                cw[pos-1] = data[di];
                di++;
            end
        end
        for (int j = 0; j < M_MAX; j++) begin
            if (j < m) begin
                p = 1'b0;
                for (int pos = 1; pos <= N_MAX; pos++)
                    if (pos <= n_of(m) && pos[j]) p ^= cw[pos-1];
                cw[(1 << j) - 1] = p;
            end
        end
        return cw;
    endfunction

endpackage

// File: rtl/hamming_cw_gen.sv
// Combinational Hamming codeword generator; appends the overall-parity bit
// above position N when EXTENDED is set.
module hamming_cw_gen
    import hamming_pkg::*;
#(
    parameter int M        = 3,
    parameter int EXTENDED = 0
) (
    input  logic [k_of(M)-1:0]          data,
    output logic [l_of(M,EXTENDED)-1:0] cw
);
    localparam int K = k_of(M);
    localparam int N = n_of(M);

    logic [K_MAX-1:0] data_ext;
    logic [N_MAX-1:0] enc;
    logic [N-1:0]     cw_n;

    assign data_ext = K_MAX'(data);
    assign enc      = hamming_encode(data_ext, M);
    assign cw_n     = N'(enc);

    generate
        if (EXTENDED != 0) begin : g_ext
            assign cw = {^cw_n, cw_n};
        end else begin : g_noext
            assign cw = cw_n;
        end
    endgenerate

endmodule

// File: rtl/hamming_stream_encoder.sv
// Parallel-in, serial-out Hamming encoder: one-word input buffer feeding an
// LSB-first shift register, with a runtime uncoded bypass.
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int M        = 3,
    parameter int EXTENDED = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [k_of(M)-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eof,
    output logic [CNT_W-1:0]   word_cnt
);
    localparam int K  = k_of(M);
    localparam int L  = l_of(M, EXTENDED);
    localparam int IW = $clog2(L + 1);

    enc_state_t      state, state_nx;
    logic            buf_full, buf_mode, rst_done;
    logic [K-1:0]    buf_data;
    logic [L-1:0]    cw, sr, load_word;
    logic [IW-1:0]   idx, last_idx, load_last;
    logic [CNT_W-1:0] cnt;
    logic            accept, adv, at_last, load;

    hamming_cw_gen #(.M(M), .EXTENDED(EXTENDED)) u_cw (
        .data (buf_data),
        .cw   (cw)
    );

    // rst_done keeps in_ready low until the first edge after reset release.
    assign in_ready  = rst_done & ~buf_full & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_SHIFT);
    assign adv       = out_valid & out_ready;
    assign at_last   = (idx == last_idx);
    assign out_bit   = out_valid & sr[0];
    assign out_sof   = out_valid & (idx == '0);
    assign out_eof   = out_valid & at_last;
    assign word_cnt  = cnt;

    assign load_word = buf_mode ? L'(buf_data) : cw;
    assign load_last = buf_mode ? IW'(K - 1) : IW'(L - 1);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    load     = 1'b1;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (adv && at_last) begin
                    if (buf_full) load = 1'b1;
                    else          state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_mode <= 1'b0;
            buf_data <= '0;
            sr       <= '0;
            idx      <= '0;
            last_idx <= '0;
            cnt      <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (load) begin
                sr       <= load_word;
                last_idx <= load_last;
                idx      <= '0;
                buf_full <= 1'b0;
            end else if (adv) begin
                sr  <= sr >> 1;
                idx <= idx + 1'b1;
            end
            // A same-edge accept refills the buffer the load just drained.
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= in_data;
                buf_mode <= mode;
                cnt      <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Scoreboard bench: dut A is M=3 extended (directed T1-T5), dut B is M=4 plain
// (exhaustive T6 with single-bit-flip decode).
module tb_hamming_stream_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_mode = 1'b0, a_valid = 1'b0, a_rdy, a_bit, a_ov, a_or = 1'b1, a_sof, a_eof;
    logic [3:0]  a_data = '0;
    logic [15:0] a_cnt;
    logic        b_mode = 1'b0, b_valid = 1'b0, b_rdy, b_bit, b_ov, b_or = 1'b1, b_sof, b_eof;
    logic [10:0] b_data = '0;
    logic [15:0] b_cnt;

    hamming_stream_encoder #(.M(3), .EXTENDED(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_rdy), .out_bit(a_bit), .out_valid(a_ov), .out_ready(a_or),
        .out_sof(a_sof), .out_eof(a_eof), .word_cnt(a_cnt));

    hamming_stream_encoder #(.M(4), .EXTENDED(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_rdy), .out_bit(b_bit), .out_valid(b_ov), .out_ready(b_or),
        .out_sof(b_sof), .out_eof(b_eof), .word_cnt(b_cnt));

    int n_chk = 0, n_err = 0;
    int a_sent = 0, b_sent = 0;
    logic [2:0]  a_q[$];
    logic [2:0]  b_q[$];
    logic [10:0] b_dq[$];
    logic        a_hold = 1'b0;
    logic [2:0]  a_held = '0;
    logic [31:0] b_cw = '0;
    int          b_pos = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Parity bits are the binary digits of the XOR of all set data positions.
    function automatic logic [31:0] ref_enc(input int m, input bit ext, input logic [25:0] d);
        logic [31:0] cw = '0;
        int n = (1 << m) - 1, di = 0, syn = 0;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[di];
                if (d[di]) syn ^= p;
                di++;
            end
        end
        for (int j = 0; j < m; j++) cw[(1 << j) - 1] = syn[j];
        if (ext) cw[n] = ^cw;
        return cw;
    endfunction

    function automatic logic [25:0] ref_dec(input int m, input logic [31:0] cw_in);
        logic [31:0] cw = cw_in;
        logic [25:0] d = '0;
        int n = (1 << m) - 1, di = 0, syn = 0;
        for (int p = 1; p <= n; p++) if (cw[p-1]) syn ^= p;
        if (syn != 0) cw[syn-1] = ~cw[syn-1];
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[di] = cw[p-1];
                di++;
            end
        end
        return d;
    endfunction

    // exp < 0 means "take the expected codeword from the reference encoder".
    task automatic send_a(input bit md, input logic [3:0] d, input int exp = -1);
        logic [31:0] cw;
        bit rdy;
        int t = 0;
        cw = (exp >= 0) ? 32'(exp) : ref_enc(3, 1'b1, {22'b0, d});
        if (md) for (int i = 0; i < 4; i++) a_q.push_back({d[i], i == 0, i == 3});
        else    for (int i = 0; i < 8; i++) a_q.push_back({cw[i], i == 0, i == 7});
        @(negedge clk);
        a_mode = md; a_data = d; a_valid = 1'b1;
        do begin
            rdy = a_rdy;
            @(posedge clk);
            t++;
        end while (!rdy && t < 500);
        chk("a_accept", 64'(rdy), 64'd1);
        if (rdy) a_sent++;
        #1 a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [10:0] d);
        logic [31:0] cw;
        bit rdy;
        int t = 0;
        cw = ref_enc(4, 1'b0, {15'b0, d});
        for (int i = 0; i < 15; i++) b_q.push_back({cw[i], i == 0, i == 14});
        b_dq.push_back(d);
        @(negedge clk);
        b_data = d; b_valid = 1'b1;
        do begin
            rdy = b_rdy;
            @(posedge clk);
            t++;
        end while (!rdy && t < 500);
        chk("b_accept", 64'(rdy), 64'd1);
        if (rdy) b_sent++;
        #1 b_valid = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        int t = 0;
        while (a_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        chk(tag, 64'(a_q.size()), 64'd0);
        chk({tag, "_word_cnt"}, 64'(a_cnt), 64'(a_sent[15:0]));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(a_rdy), 64'd0);
        chk({tag, "_outs"}, 64'({a_ov, a_bit, a_sof, a_eof}), 64'd0);
        chk({tag, "_word_cnt"}, 64'(a_cnt), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            a_hold <= 1'b0;
        end else begin
            if (a_hold && a_ov) chk("t4_stall_hold", 64'({a_bit, a_sof, a_eof}), 64'(a_held));
            if (a_ov && a_or) begin
                if (a_q.size() == 0) chk("a_extra_bit", 64'd1, 64'd0);
                else                 chk("a_bit_sof_eof", 64'({a_bit, a_sof, a_eof}), 64'(a_q.pop_front()));
            end
            a_hold <= a_ov && !a_or;
            a_held <= {a_bit, a_sof, a_eof};
        end
    end

    always @(negedge clk) begin
        logic [31:0] w;
        logic [10:0] d;
        int bad;
        if (!rst && b_ov && b_or) begin
            if (b_q.size() == 0) chk("b_extra_bit", 64'd1, 64'd0);
            else                 chk("t6_bit_sof_eof", 64'({b_bit, b_sof, b_eof}), 64'(b_q.pop_front()));
            w = b_cw;
            w[b_pos] = b_bit;
            if (b_eof) begin
                d = (b_dq.size() != 0) ? b_dq.pop_front() : 11'h0;
                bad = (ref_dec(4, w) !== 26'(d)) ? 1 : 0;
                for (int f = 0; f < 15; f++)
                    if (ref_dec(4, w ^ (32'd1 << f)) !== 26'(d)) bad++;
                chk("t6_flip_decode", 64'(bad), 64'd0);
                b_cw  <= '0;
                b_pos <= 0;
            end else begin
                b_cw  <= w;
                b_pos <= b_pos + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int ones;
        // reset state, then in_ready rises on the first edge after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk); #1 rst = 1'b0;
        chk("in_ready_before_edge", 64'(a_rdy), 64'd0);
        @(posedge clk); #1;
        chk("in_ready_after_release", 64'(a_rdy), 64'd1);

        // T1: 1011 coded+ext, first bit one edge after the accept edge
        send_a(1'b0, 4'b1011, 8'h55);
        chk("t1_not_yet_valid", 64'(a_ov), 64'd0);
        @(posedge clk); #1;
        chk("t1_latency_sof", 64'({a_ov, a_sof}), 64'b11);
        drain_a("t1_drain");

        // T2: back-to-back all-ones / all-zeros words with no gap
        fork
            begin
                send_a(1'b0, 4'hF, 8'hFF);
                send_a(1'b0, 4'h0, 8'h00);
            end
            begin
                t = 0;
                do begin
                    @(posedge clk); #1;
                    t++;
                end while (!(a_ov && a_sof) && t < 50);
                ones = 0;
                repeat (16) begin
                    if (a_ov) ones++;
                    @(posedge clk); #1;
                end
                chk("t2_gapless", 64'(ones), 64'd16);
            end
        join
        drain_a("t2_drain");
        chk("t2_word_cnt_two", 64'(a_cnt), 64'd3);

        // T3: bypass word then a coded word
        send_a(1'b1, 4'b1011, 4'b1011);
        send_a(1'b0, 4'b0110);
        drain_a("t3_drain");

        // T4: random out_ready stalls; second word waits in the buffer
        fork
            begin
                send_a(1'b0, 4'b1001);
                send_a(1'b0, 4'b0111);
                chk("t4_in_ready_held_low", 64'(a_rdy), 64'd0);
                send_a(1'b1, 4'b1100);
            end
            begin
                repeat (80) begin
                    @(posedge clk); #1;
                    a_or = 1'($urandom_range(0, 1));
                end
                a_or = 1'b1;
            end
        join
        drain_a("t4_drain");

        // T5: reset on the third bit of a word
        send_a(1'b0, 4'b1101);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(a_ov && a_sof) && t < 50);
        chk("t5_saw_sof", 64'(a_sof), 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        a_q.delete();
        a_sent = 0;
        @(negedge clk);
        chk_reset_state("t5_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_in_ready_after", 64'(a_rdy), 64'd1);
        send_a(1'b0, 4'b0011);
        drain_a("t5_drain");

        // T6: every 11-bit word through the M=4 encoder
        for (int w = 0; w < 2048; w++) send_b(11'(w));
        t = 0;
        while (b_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        chk("t6_drain", 64'(b_q.size()), 64'd0);
        chk("t6_word_cnt", 64'(b_cnt), 64'(b_sent[15:0]));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
